// File: rtl/ps2_pkg.sv
// rtl/ps2_pkg.sv - shared PS/2 frame types, constants and frame builders
package ps2_pkg;

    typedef enum logic [1:0] {IDLE, HIGH, LOW, GAP} ps2_tx_state_t;

    localparam int PS2_FRAME_BITS = 11;

    function automatic logic ps2_odd_parity(input logic [7:0] data);
        return ~^data;
    endfunction

    // Bit 0 is sent first: start, data LSB first, parity, stop.
    function automatic logic [PS2_FRAME_BITS-1:0] ps2_frame(input logic [7:0] data);
        return {1'b1, ps2_odd_parity(data), data, 1'b0};
    endfunction

endpackage

// File: rtl/ps2_tx_fifo.sv
// rtl/ps2_tx_fifo.sv - small synchronous byte FIFO with registered full/empty flags
module ps2_tx_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic [AW:0]      count_nxt;
    logic             do_push;
    logic             do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    always_comb begin
        count_nxt = count;
        if (do_push && !do_pop) begin
            count_nxt = count + (AW+1)'(1);
        end else if (do_pop && !do_push) begin
            count_nxt = count - (AW+1)'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count <= count_nxt;
            full  <= (count_nxt == FULL_COUNT);
            empty <= (count_nxt == '0);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

endmodule

// File: rtl/ps2_key_tx.sv
// rtl/ps2_key_tx.sv - PS/2 device-side transmitter driving KEYSIG_CLK/KEYSIG_DATA from a byte FIFO
module ps2_key_tx
    import ps2_pkg::*;
#(
    parameter int HALF_CYCLES = 4000,
    parameter int GAP_CYCLES  = 8000,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    input  logic       inhibit,
    output logic       busy,
    output logic       KEYSIG_CLK,
    output logic       KEYSIG_DATA
);

    localparam int MAX_CYCLES = (HALF_CYCLES > GAP_CYCLES) ? HALF_CYCLES : GAP_CYCLES;
    localparam int PW         = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;
    localparam logic [PW-1:0] HALF_LOAD = PW'(HALF_CYCLES - 1);
    localparam logic [PW-1:0] GAP_LOAD  = PW'(GAP_CYCLES - 1);
    localparam logic [3:0]    LAST_BIT  = 4'(PS2_FRAME_BITS - 1);

    ps2_tx_state_t             state;
    logic [PW-1:0]             phase;
    logic [3:0]                bit_idx;
    logic [3:0]                next_bit;
    logic                      fifo_full;
    logic                      fifo_empty;
    logic                      push;
    logic                      pop;
    logic [7:0]                head;
    logic [PS2_FRAME_BITS-1:0] head_frame;
    logic                      phase_done;
    logic                      abort;

    assign tx_ready   = !fifo_full;
    assign push       = tx_valid && !fifo_full;
    assign phase_done = (phase == '0);
    assign next_bit   = bit_idx + 4'd1;
    // The stop-bit slot is committed: host inhibit there no longer aborts.
    assign abort      = inhibit && (bit_idx != LAST_BIT);
    assign pop        = (state == LOW) && phase_done && (bit_idx == LAST_BIT);
    assign head_frame = ps2_frame(head);
    assign busy       = (state != IDLE) || !fifo_empty;

    ps2_tx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clk       (clk),
        .reset_n   (reset_n),
        .push      (push),
        .push_data (tx_data),
        .pop       (pop),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .head      (head)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            phase       <= '0;
            bit_idx     <= '0;
            KEYSIG_CLK  <= 1'b1;
            KEYSIG_DATA <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (!fifo_empty && !inhibit) begin
                        state       <= HIGH;
                        phase       <= HALF_LOAD;
                        bit_idx     <= '0;
                        KEYSIG_CLK  <= 1'b1;
                        KEYSIG_DATA <= head_frame[0];
                    end
                end
                HIGH, LOW: begin
                    if (abort) begin
                        state       <= GAP;
                        phase       <= GAP_LOAD;
                        bit_idx     <= '0;
                        KEYSIG_CLK  <= 1'b1;
                        KEYSIG_DATA <= 1'b1;
                    end else if (!phase_done) begin
                        phase <= phase - PW'(1);
                    end else if (state == HIGH) begin
                        state      <= LOW;
                        phase      <= HALF_LOAD;
                        KEYSIG_CLK <= 1'b0;
                    end else if (bit_idx == LAST_BIT) begin
                        state       <= GAP;
                        phase       <= GAP_LOAD;
                        KEYSIG_CLK  <= 1'b1;
                        KEYSIG_DATA <= 1'b1;
                    end else begin
                        state       <= HIGH;
                        phase       <= HALF_LOAD;
                        bit_idx     <= next_bit;
                        KEYSIG_CLK  <= 1'b1;
                        KEYSIG_DATA <= head_frame[next_bit];
                    end
                end
                GAP: begin
                    if (!phase_done) begin
                        phase <= phase - PW'(1);
                    end else begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ps2_key_tx.sv
// tb/tb_ps2_key_tx.sv - scoreboard bench decoding the PS/2 lines against a byte-level model
module tb_ps2_key_tx;

    localparam int HALF  = 4;
    localparam int GAP   = 8;
    localparam int DEPTH = 4;

    logic       clk      = 1'b0;
    logic       reset_n  = 1'b1;
    logic [7:0] tx_data  = 8'h00;
    logic       tx_valid = 1'b0;
    logic       inhibit  = 1'b0;
    logic       tx_ready;
    logic       busy;
    logic       KEYSIG_CLK;
    logic       KEYSIG_DATA;

    ps2_key_tx #(
        .HALF_CYCLES (HALF),
        .GAP_CYCLES  (GAP),
        .FIFO_DEPTH  (DEPTH)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .tx_data     (tx_data),
        .tx_valid    (tx_valid),
        .tx_ready    (tx_ready),
        .inhibit     (inhibit),
        .busy        (busy),
        .KEYSIG_CLK  (KEYSIG_CLK),
        .KEYSIG_DATA (KEYSIG_DATA)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [7:0]  exp_q[$];
    int          cyc = 0, nbits = 0, frames = 0, aborts = 0;
    int          high_run = 0, first_fall = 0, last_end = 0;
    bit          have_end = 0;
    logic        prev_clk = 1'b1, prev_data = 1'b1;
    logic [10:0] bits = '0, last_bits = '0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    function automatic logic [10:0] model_bits(input logic [7:0] b);
        logic [10:0] f;
        int ones;
        ones = 0;
        f[0] = 1'b0;
        for (int i = 0; i < 8; i++) begin
            f[i+1] = b[i];
            ones += int'(b[i]);
        end
        f[9]  = (ones % 2 == 0);
        f[10] = 1'b1;
        return f;
    endfunction

    // Line monitor: decodes frames on falling KEYSIG_CLK and scores them against exp_q.
    always @(negedge clk) begin
        logic [7:0] e;
        cyc++;
        if (!reset_n) begin
            nbits    = 0;
            high_run = 0;
            have_end = 0;
        end else begin
            if (!prev_clk && !KEYSIG_CLK)
                check("data_stable_while_clk_low", int'(KEYSIG_DATA), int'(prev_data));
            if (prev_clk && !KEYSIG_CLK) begin
                if (nbits == 0) first_fall = cyc;
                if (nbits < 11) bits[nbits] = KEYSIG_DATA;
                nbits++;
            end
            if (!prev_clk && KEYSIG_CLK && nbits == 11) begin
                check("frame_duration", cyc - first_fall, 21 * HALF);
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_frame: got bits 0x%0h, expected no frame", bits);
                end else begin
                    e = exp_q.pop_front();
                    check($sformatf("frame_bits_for_0x%0h", e), int'(bits), int'(model_bits(e)));
                end
                last_bits = bits;
                frames++;
                nbits    = 0;
                last_end = cyc;
                have_end = 1;
            end
            high_run = KEYSIG_CLK ? high_run + 1 : 0;
            if (high_run > HALF + 1 && nbits != 0) begin
                aborts++;
                nbits = 0;
            end
            if (have_end && prev_data && !KEYSIG_DATA) begin
                check($sformatf("gap_ge_%0d_cycles_(%0d)", GAP, cyc - last_end),
                      int'((cyc - last_end) >= GAP), 1);
                have_end = 0;
            end
        end
        prev_clk  = KEYSIG_CLK;
        prev_data = KEYSIG_DATA;
    end

    task automatic push(input logic [7:0] d, output int waited);
        waited   = 0;
        tx_data  = d;
        tx_valid = 1'b1;
        while (!tx_ready && waited < 3000) begin
            @(negedge clk);
            waited++;
        end
        if (!tx_ready) begin
            n_checks++;
            n_fail++;
            $display("FAIL push_timeout: got tx_ready=0 after %0d cycles, expected 1", waited);
        end else begin
            exp_q.push_back(d);
            @(negedge clk);
        end
        tx_valid = 1'b0;
    endtask

    task automatic wait_slot(input int n, input logic clk_level);
        bit ok;
        ok = 0;
        for (int t = 0; t < 3000 && !ok; t++) begin
            @(negedge clk);
            #1;
            if (nbits == n && KEYSIG_CLK == clk_level) ok = 1;
        end
        if (!ok) begin
            n_checks++;
            n_fail++;
            $display("FAIL slot_wait_timeout: got no slot %0d phase %0d, expected it", n, clk_level);
        end
    endtask

    task automatic wait_idle();
        bit ok;
        ok = 0;
        for (int t = 0; t < 20000 && !ok; t++) begin
            @(negedge clk);
            #1;
            if (!busy) ok = 1;
        end
        if (!ok) begin
            n_checks++;
            n_fail++;
            $display("FAIL idle_timeout: got busy=1, expected 0");
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got no finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int   w, f0, a0;
        bit   done;
        logic [7:0] par_bytes [3];
        logic       par_exp   [3];
        par_bytes = '{8'h00, 8'hFF, 8'h01};
        par_exp   = '{1'b1, 1'b1, 1'b0};

        #1 reset_n = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_clk", int'(KEYSIG_CLK), 1);
        check("reset_data", int'(KEYSIG_DATA), 1);
        check("reset_busy", int'(busy), 0);
        check("reset_ready", int'(tx_ready), 1);
        reset_n = 1'b1;
        @(negedge clk);

        f0 = frames;
        push(8'h1C, w);
        wait_idle();
        check("t1_bits_1c", int'(last_bits), int'(11'b10000111000));
        check("t1_frames", frames - f0, 1);

        for (int i = 0; i < 3; i++) begin
            push(par_bytes[i], w);
            wait_idle();
            check($sformatf("t2_parity_0x%0h", par_bytes[i]), int'(last_bits[9]), int'(par_exp[i]));
            check($sformatf("t2_stop_0x%0h", par_bytes[i]), int'(last_bits[10]), 1);
        end

        f0 = frames;
        push(8'hF0, w);
        push(8'h1C, w);
        push(8'h12, w);
        push(8'h59, w);
        check("t3_ready_low_when_full", int'(tx_ready), 0);
        push(8'hAA, w);
        check($sformatf("t3_fifth_held_(%0d)", w), int'(w >= 16 * HALF), 1);
        wait_idle();
        check("t3_frames", frames - f0, 5);
        check("t3_queue_drained", exp_q.size(), 0);

        f0 = frames;
        a0 = aborts;
        push(8'h1C, w);
        wait_slot(6, 1'b0);
        inhibit = 1'b1;
        @(negedge clk);
        #1;
        check("t4_abort_clk_high", int'(KEYSIG_CLK), 1);
        check("t4_abort_data_high", int'(KEYSIG_DATA), 1);
        check("t4_busy_during_abort", int'(busy), 1);
        repeat (19) @(negedge clk);
        inhibit = 1'b0;
        wait_idle();
        check("t4_one_frame", frames - f0, 1);
        check("t4_one_abort", aborts - a0, 1);
        check("t4_queue_drained", exp_q.size(), 0);

        f0 = frames;
        a0 = aborts;
        push(8'h1C, w);
        wait_slot(10, 1'b1);
        inhibit = 1'b1;
        repeat (2) @(negedge clk);
        inhibit = 1'b0;
        wait_idle();
        repeat (60) @(negedge clk);
        #1;
        check("t5_one_frame", frames - f0, 1);
        check("t5_no_abort", aborts - a0, 0);
        check("t5_no_resend", nbits, 0);

        f0 = frames;
        push(8'hA1, w);
        push(8'hB2, w);
        wait_slot(3, 1'b1);
        #2;
        reset_n = 1'b0;
        #1;
        check("t6_clk_async", int'(KEYSIG_CLK), 1);
        check("t6_data_async", int'(KEYSIG_DATA), 1);
        check("t6_busy_async", int'(busy), 0);
        check("t6_ready_async", int'(tx_ready), 1);
        exp_q.delete();
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        repeat (200) @(negedge clk);
        #1;
        check("t6_no_frames", frames - f0, 0);
        check("t6_clk_idle", int'(KEYSIG_CLK), 1);
        check("t6_data_idle", int'(KEYSIG_DATA), 1);
        check("t6_busy_idle", int'(busy), 0);

        f0 = frames;
        done = 0;
        fork
            begin
                for (int i = 0; i < 24; i++) begin
                    push(8'($urandom_range(0, 255)), w);
                    repeat ($urandom_range(0, 150)) @(negedge clk);
                end
                done = 1;
            end
            begin
                while (!done) begin
                    repeat ($urandom_range(100, 400)) @(negedge clk);
                    if (!done) begin
                        inhibit = 1'b1;
                        repeat ($urandom_range(1, 25)) @(negedge clk);
                        inhibit = 1'b0;
                    end
                end
            end
        join
        inhibit = 1'b0;
        wait_idle();
        check("t7_frames", frames - f0, 24);
        check("t7_queue_drained", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
